// File: rtl/decode_buffer_pkg.sv
// Shared defines for decode_buffer: opcodes, instruction-type encodings, CSR funct3 codes and the
// decoded-field bundle carried from decode_fields into the output stage.
package decode_buffer_pkg;

    localparam logic [6:0] OpLoad    = 7'h03;
    localparam logic [6:0] OpLoadFp  = 7'h07;
    localparam logic [6:0] OpOpImm   = 7'h13;
    localparam logic [6:0] OpAuipc   = 7'h17;
    localparam logic [6:0] OpOpImm32 = 7'h1B;
    localparam logic [6:0] OpStore   = 7'h23;
    localparam logic [6:0] OpStoreFp = 7'h27;
    localparam logic [6:0] OpOp      = 7'h33;
    localparam logic [6:0] OpLui     = 7'h37;
    localparam logic [6:0] OpOpFp    = 7'h53;
    localparam logic [6:0] OpBranch  = 7'h63;
    localparam logic [6:0] OpJalr    = 7'h67;
    localparam logic [6:0] OpJal     = 7'h6F;
    localparam logic [6:0] OpSystem  = 7'h73;

    localparam logic [2:0] Funct3Csrrw  = 3'b001;
    localparam logic [2:0] Funct3Csrrs  = 3'b010;
    localparam logic [2:0] Funct3Csrrc  = 3'b011;
    localparam logic [2:0] Funct3Csrrwi = 3'b101;
    localparam logic [2:0] Funct3Csrrsi = 3'b110;
    localparam logic [2:0] Funct3Csrrci = 3'b111;

    typedef enum logic [2:0] {
        TypeNone = 3'd0,
        TypeR    = 3'd1,
        TypeI    = 3'd2,
        TypeS    = 3'd3,
        TypeB    = 3'd4,
        TypeU    = 3'd5,
        TypeJ    = 3'd6
    } instr_type_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] funct12;
        logic [4:0]  read_index_1;
        logic [4:0]  read_index_2;
        logic [4:0]  write_index;
        logic [11:0] csr_index;
        instr_type_e instruction_type;
        logic        read_enable_1;
        logic        read_enable_2;
        logic        write_enable;
        logic        read_enable_csr;
        logic        write_enable_csr;
        logic        illegal;
    } decode_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/decode_buffer_if.sv
// Fetch-side and decode-side handshake bundle for decode_buffer.
// slave is the buffer itself; master is the fetch/consumer environment.
interface decode_buffer_if
    import decode_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned OccW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instruction;
    logic [31:0]     in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_pc;
    logic [31:0]     out_instruction;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [11:0]     funct12;
    logic [4:0]      read_index_1;
    logic [4:0]      read_index_2;
    logic [4:0]      write_index;
    logic [11:0]     csr_index;
    instr_type_e     instruction_type;
    logic            read_enable_1;
    logic            read_enable_2;
    logic            write_enable;
    logic            read_enable_csr;
    logic            write_enable_csr;
    logic            illegal;
    logic [OccW-1:0] occupancy;

    modport master (
        output in_valid, in_instruction, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instruction, opcode, funct3, funct7, funct12,
               read_index_1, read_index_2, write_index, csr_index, instruction_type,
               read_enable_1, read_enable_2, write_enable, read_enable_csr, write_enable_csr,
               illegal, occupancy
    );

    modport slave (
        input  in_valid, in_instruction, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instruction, opcode, funct3, funct7, funct12,
               read_index_1, read_index_2, write_index, csr_index, instruction_type,
               read_enable_1, read_enable_2, write_enable, read_enable_csr, write_enable_csr,
               illegal, occupancy
    );

endinterface

// File: rtl/decode_fields.sv
// Combinational RV32 field extraction, class decode and enable generation.
// CSR enables are produced only when DECODE_BUFFER_CSR_EN is defined; otherwise they stay 0.
module decode_fields
    import decode_buffer_pkg::*;
(
    input  logic [31:0] instruction,
    output decode_t     decoded
);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];

    always_comb begin
        decoded                  = '0;
        decoded.opcode           = opcode;
        decoded.funct3           = funct3;
        decoded.funct7           = instruction[31:25];
        decoded.funct12          = instruction[31:20];
        decoded.read_index_1     = instruction[19:15];
        decoded.read_index_2     = instruction[24:20];
        decoded.write_index      = instruction[11:7];
        decoded.csr_index        = instruction[31:20];
        decoded.instruction_type = TypeNone;

        // Every listed opcode ends in 2'b11, so the compressed-encoding check falls out here.
        unique case (opcode)
            OpOp, OpOpFp: begin
                decoded.instruction_type = TypeR;
                decoded.read_enable_1    = 1'b1;
                decoded.read_enable_2    = 1'b1;
                decoded.write_enable     = 1'b1;
            end
            OpLoad, OpLoadFp, OpOpImm, OpOpImm32, OpJalr, OpSystem: begin
                decoded.instruction_type = TypeI;
                decoded.read_enable_1    = 1'b1;
                decoded.write_enable     = 1'b1;
            end
            OpStore, OpStoreFp: begin
                decoded.instruction_type = TypeS;
                decoded.read_enable_1    = 1'b1;
                decoded.read_enable_2    = 1'b1;
            end
            OpBranch: begin
                decoded.instruction_type = TypeB;
                decoded.read_enable_1    = 1'b1;
                decoded.read_enable_2    = 1'b1;
            end
            OpAuipc, OpLui: begin
                decoded.instruction_type = TypeU;
                decoded.write_enable     = 1'b1;
            end
            OpJal: begin
                decoded.instruction_type = TypeJ;
                decoded.write_enable     = 1'b1;
            end
            default: begin
                decoded.illegal = 1'b1;
            end
        endcase

        if (instruction[11:7] == 5'd0) begin
            decoded.write_enable = 1'b0;
        end

`ifdef DECODE_BUFFER_CSR_EN
        if (opcode == OpSystem && funct3 inside {Funct3Csrrw, Funct3Csrrs, Funct3Csrrc,
                                                 Funct3Csrrwi, Funct3Csrrsi, Funct3Csrrci}) begin
            decoded.read_enable_csr  = 1'b1;
            decoded.write_enable_csr = 1'b1;
            if (instruction[31:30] == 2'b11) begin
                decoded.write_enable_csr = 1'b0;
            end
            // Set/clear with a zero rs1 or zero uimm must not cause a CSR write side effect.
            if (funct3 inside {Funct3Csrrs, Funct3Csrrc, Funct3Csrrsi, Funct3Csrrci} &&
                instruction[19:15] == 5'd0) begin
                decoded.write_enable_csr = 1'b0;
            end
        end
`endif
    end

endmodule

// File: rtl/decode_buffer.sv
// Instruction FIFO plus registered decode stage between fetch and register-file read.
// Optional CSR enable decode is selected by the DECODE_BUFFER_CSR_EN macro.
module decode_buffer
    import decode_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic            clk,
    input logic            reset,
    decode_buffer_if.slave bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    fetch_entry_t    fifo_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            out_valid_q;
    decode_t         dec_q;
    fetch_entry_t    out_entry_q;

    logic         push, fifo_empty, load, pop, bypass, fifo_write;
    fetch_entry_t incoming, src;
    decode_t      src_dec;

    assign bus.in_ready = reset & ~bus.flush & (count_q < DepthCnt);
    assign push         = bus.in_valid & bus.in_ready;
    assign fifo_empty   = (count_q == '0);
    assign load         = ~out_valid_q | bus.out_ready;
    assign pop          = load & ~fifo_empty;
    // Bypass only when the FIFO is empty, so older entries always leave first.
    assign bypass       = load & fifo_empty & push;
    assign fifo_write   = push & ~bypass;
    assign incoming     = {bus.in_pc, bus.in_instruction};
    assign src          = fifo_empty ? incoming : fifo_q[rd_ptr_q];

    decode_fields u_decode_fields (
        .instruction (src.instruction),
        .decoded     (src_dec)
    );

    always_ff @(posedge clk) begin
        if (fifo_write) begin
            fifo_q[wr_ptr_q] <= incoming;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            dec_q       <= '0;
            out_entry_q <= '0;
        end else if (bus.flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (fifo_write) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(fifo_write) - CntW'(pop);
            if (load) begin
                out_valid_q <= pop | bypass;
                if (pop | bypass) begin
                    dec_q       <= src_dec;
                    out_entry_q <= src;
                end
            end
        end
    end

    assign bus.out_valid        = out_valid_q;
    assign bus.out_pc           = out_entry_q.pc;
    assign bus.out_instruction  = out_entry_q.instruction;
    assign bus.opcode           = dec_q.opcode;
    assign bus.funct3           = dec_q.funct3;
    assign bus.funct7           = dec_q.funct7;
    assign bus.funct12          = dec_q.funct12;
    assign bus.read_index_1     = dec_q.read_index_1;
    assign bus.read_index_2     = dec_q.read_index_2;
    assign bus.write_index      = dec_q.write_index;
    assign bus.csr_index        = dec_q.csr_index;
    assign bus.instruction_type = dec_q.instruction_type;
    assign bus.read_enable_1    = dec_q.read_enable_1;
    assign bus.read_enable_2    = dec_q.read_enable_2;
    assign bus.write_enable     = dec_q.write_enable;
    assign bus.read_enable_csr  = dec_q.read_enable_csr;
    assign bus.write_enable_csr = dec_q.write_enable_csr;
    assign bus.illegal          = dec_q.illegal;
    assign bus.occupancy        = count_q;

endmodule

// File: tb/tb_decode_buffer.sv
// Randomised bench for decode_buffer against a queue-based transaction model of the buffer and a
// table-driven decode reference; directed cases cover fill/drain, flush, reset and CSR handling.
module tb_decode_buffer;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    decode_buffer_if #(.DEPTH(DEPTH)) bus ();

    decode_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mfifo [$];
    logic [63:0] mout;
    bit          mout_v;

    logic [6:0] opc_tbl [16] = '{7'h33, 7'h53, 7'h03, 7'h07, 7'h13, 7'h1B, 7'h67, 7'h73,
                                 7'h23, 7'h27, 7'h63, 7'h17, 7'h37, 7'h6F, 7'h7F, 7'h3B};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {type[2:0], re1, re2, we, re_csr, we_csr, illegal}
    function automatic logic [8:0] ref_ctl(input logic [31:0] ins);
        logic [2:0] t;
        logic       r1, r2, w, rc, wc, il;
        logic [2:0] f3;
        f3 = ins[14:12];
        {r1, r2, w, rc, wc, il} = 6'b0;
        case (ins[6:0])
            7'h33, 7'h53:                               begin t = 3'd1; {r1, r2, w} = 3'b111; end
            7'h03, 7'h07, 7'h13, 7'h1B, 7'h67, 7'h73:   begin t = 3'd2; {r1, r2, w} = 3'b101; end
            7'h23, 7'h27:                               begin t = 3'd3; {r1, r2, w} = 3'b110; end
            7'h63:                                      begin t = 3'd4; {r1, r2, w} = 3'b110; end
            7'h17, 7'h37:                               begin t = 3'd5; {r1, r2, w} = 3'b001; end
            7'h6F:                                      begin t = 3'd6; {r1, r2, w} = 3'b001; end
            default:                                    begin t = 3'd0; il = 1'b1; end
        endcase
        if (ins[11:7] == 5'd0) w = 1'b0;
`ifdef DECODE_BUFFER_CSR_EN
        if (ins[6:0] == 7'h73 && f3 != 3'd0 && f3 != 3'd4) begin
            rc = 1'b1;
            wc = (ins[31:30] != 2'b11);
            if ((f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) && ins[19:15] == 5'd0)
                wc = 1'b0;
        end
`endif
        return {t, r1, r2, w, rc, wc, il};
    endfunction

    function automatic logic [55:0] ref_fields(input logic [31:0] ins);
        return {ins[6:0], ins[14:12], ins[31:25], ins[31:20], ins[19:15], ins[24:20], ins[11:7],
                ins[31:20]};
    endfunction

    function automatic logic [8:0] dut_ctl();
        return {bus.instruction_type, bus.read_enable_1, bus.read_enable_2, bus.write_enable,
                bus.read_enable_csr, bus.write_enable_csr, bus.illegal};
    endfunction

    function automatic logic [55:0] dut_fields();
        return {bus.opcode, bus.funct3, bus.funct7, bus.funct12, bus.read_index_1,
                bus.read_index_2, bus.write_index, bus.csr_index};
    endfunction

    function automatic bit model_ready(input logic fl);
        return rst_n && !fl && (mfifo.size() < DEPTH);
    endfunction

    task automatic model_update(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                                input logic ordy, input logic fl);
        bit push = iv && model_ready(fl);
        bit load = !mout_v || ordy;
        if (fl) begin
            mfifo.delete();
            mout_v = 0;
        end else if (load) begin
            if (mfifo.size() > 0) begin
                mout   = mfifo.pop_front();
                mout_v = 1;
                if (push) mfifo.push_back({pc, ins});
            end else if (push) begin
                mout   = {pc, ins};
                mout_v = 1;
            end else begin
                mout_v = 0;
            end
        end else if (push) begin
            mfifo.push_back({pc, ins});
        end
    endtask

    task automatic check_outputs();
        check_eq("out_valid", bus.out_valid, mout_v);
        check_eq("occupancy", bus.occupancy, mfifo.size());
        if (mout_v) begin
            check_eq("out_pc", bus.out_pc, mout[63:32]);
            check_eq("out_instr", bus.out_instruction, mout[31:0]);
            check_eq("fields", dut_fields(), ref_fields(mout[31:0]));
            check_eq("ctl", dut_ctl(), ref_ctl(mout[31:0]));
        end
    endtask

    // Called just after a falling edge: drive, check in_ready, clock, update model, check.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        bus.in_valid       = iv;
        bus.in_instruction = ins;
        bus.in_pc          = pc;
        bus.out_ready      = ordy;
        bus.flush          = fl;
        #1;
        check_eq("in_ready", bus.in_ready, model_ready(fl));
        @(posedge clk);
        model_update(iv, ins, pc, ordy, fl);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) == 0) return r;
        return {r[31:7], opc_tbl[$urandom_range(0, 15)]};
    endfunction

    logic [8:0] exp_ctl;

    initial begin
        n_vec = 0;
        n_err = 0;
        mout_v = 0;
        mout = '0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instruction = '0;
        bus.in_pc = '0;
        bus.out_ready = 1'b0;
        bus.flush = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_occ", bus.occupancy, 0);
        check_eq("rst_valid", bus.out_valid, 0);
        check_eq("rst_ready", bus.in_ready, 0);
        #2 rst_n = 1'b1;

        // Single ADD into empty buffer: visible next cycle via bypass.
        step(1, 32'h002081B3, 32'h100, 1, 0);
        check_eq("add_valid", bus.out_valid, 1);
        check_eq("add_ctl", dut_ctl(), {3'd1, 6'b111000});
        check_eq("add_occ", bus.occupancy, 0);
        step(0, 0, 0, 1, 0);

        // Fill DEPTH+1 with out_ready low, then drain in order.
        for (int k = 0; k <= DEPTH; k++) step(1, rand_instr(), 32'h200 + 4 * k, 0, 0);
        check_eq("full_occ", bus.occupancy, DEPTH);
        check_eq("full_pc", bus.out_pc, 32'h200);
        #1 check_eq("full_ready", bus.in_ready, 0);
        for (int k = 1; k <= DEPTH; k++) begin
            step(0, 0, 0, 1, 0);
            check_eq("drain_pc", bus.out_pc, 32'h200 + 4 * k);
        end
        step(0, 0, 0, 1, 0);
        check_eq("drain_done", bus.out_valid, 0);

        step(1, 32'h00000013, 32'h300, 1, 0);
        check_eq("addi_x0", dut_ctl(), {3'd2, 6'b100000});
        step(1, 32'h0000007F, 32'h304, 1, 0);
        check_eq("illegal", dut_ctl(), {3'd0, 6'b000001});

`ifdef DECODE_BUFFER_CSR_EN
        exp_ctl = {3'd2, 6'b101100};
`else
        exp_ctl = {3'd2, 6'b101000};
`endif
        step(1, 32'hB00022F3, 32'h308, 1, 0);
        check_eq("csrrs_mcycle", dut_ctl(), exp_ctl);
`ifdef DECODE_BUFFER_CSR_EN
        exp_ctl = {3'd2, 6'b100100};
`else
        exp_ctl = {3'd2, 6'b100000};
`endif
        step(1, 32'hC0009073, 32'h30C, 1, 0);
        check_eq("csrrw_ro", dut_ctl(), exp_ctl);
`ifdef DECODE_BUFFER_CSR_EN
        exp_ctl = {3'd2, 6'b100110};
`else
        exp_ctl = {3'd2, 6'b100000};
`endif
        step(1, 32'h30009073, 32'h310, 1, 0);
        check_eq("csrrw_rw", dut_ctl(), exp_ctl);
        step(0, 0, 0, 1, 0);

        // Flush with occupancy 3 and a simultaneous offer.
        for (int k = 0; k < 4; k++) step(1, rand_instr(), 32'h400 + 4 * k, 0, 0);
        check_eq("pre_flush_occ", bus.occupancy, 3);
        check_eq("pre_flush_valid", bus.out_valid, 1);
        step(1, 32'h002081B3, 32'h500, 1, 1);
        check_eq("flush_occ", bus.occupancy, 0);
        check_eq("flush_valid", bus.out_valid, 0);
        bus.flush = 1'b0;
        #1 check_eq("flush_ready", bus.in_ready, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0);

        // Random streaming with an asynchronous reset pulse partway through.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("arst_occ", bus.occupancy, 0);
                check_eq("arst_valid", bus.out_valid, 0);
                check_eq("arst_ready", bus.in_ready, 0);
                check_eq("arst_pc", bus.out_pc, 0);
                check_eq("arst_instr", bus.out_instruction, 0);
                check_eq("arst_fields", dut_fields(), 0);
                check_eq("arst_ctl", dut_ctl(), 0);
                mfifo.delete();
                mout_v = 0;
                @(posedge clk);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_buffer.md
# decode_buffer

Parametrised instruction queue and registered decode stage between fetch and the register-file read stage. Fetched instruction/PC pairs are buffered in a DEPTH-entry FIFO, decoded in order, and presented one per cycle through a valid/ready handshake. The decoded fields include register-file and CSR enables. Adds back-pressure, flush, illegal-opcode detection and CSR write-side-effect suppression to the existing decode function.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  buffer accepts; transfer when in_valid & in_ready
- in_instruction  in  32  raw instruction
- in_pc  in  32  its address
- flush  in  1  discard everything buffered and in the output stage
- out_valid  out  1  decoded instruction present
- out_ready  in  1  consumer takes it; transfer when out_valid & out_ready
- out_pc, out_instruction  out  32 each  pass-through of accepted pair
- opcode 7, funct3 3, funct7 7, funct12 12  out  instruction fields
- read_index_1, read_index_2, write_index  out  5 each  register indices
- csr_index  out  12  CSR address
- instruction_type  out  3  R/I/S/B/U/J encoding from shared defines; NONE for illegal
- read_enable_1, read_enable_2, write_enable  out  1 each  register-file enables
- read_enable_csr, write_enable_csr  out  1 each  CSR enables
- illegal  out  1  opcode not recognised or instruction[1:0] != 2'b11
- occupancy  out  $clog2(DEPTH)+1  FIFO entries held, excluding output stage

## Operation
- Storage: FIFO of {pc, instruction}; read/write pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
- Output stage: one register holding all decoded outputs plus out_valid. Loads when `!out_valid | out_ready`.
- Load source:
  - FIFO head when occupancy > 0.
  - Otherwise the incoming instruction directly (bypass) when in_valid & in_ready.
  - Bypass is never used while the FIFO is non-empty, so order is preserved.
- in_ready = reset deasserted & !flush & (occupancy < DEPTH). Uses current occupancy only; a pop in the same cycle does not free a slot for a push at full.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, both pointers advance.
- Decode classes:
  - OP, OP_FP → R.
  - LOAD, LOAD_FP, OP_IMM, OP_IMM_32, JALR, SYSTEM → I.
  - STORE, STORE_FP → S.
  - BRANCH → B.
  - AUIPC, LUI → U.
  - JAL → J.
  - Anything else → NONE with illegal=1.
- Enable table per class is identical to the existing decoder. NONE gives all enables 0.
- write_enable is forced 0 when write_index == 0.
- Illegal instructions still travel the handshake and are not dropped.
- flush: at the next edge, occupancy=0, pointers=0, out_valid=0. No push occurs in the flush cycle. An out_ready in the same cycle as flush has no further effect.
- Reset (asynchronous, any time including mid-transfer): occupancy=0, pointers=0, out_valid=0, all decoded outputs and out_pc/out_instruction = 0, in_ready=0 while reset is low.

## Timing
- Latency, empty buffer: accepted at edge N, out_valid=1 in cycle N+1 (bypass).
- Latency, non-empty buffer: one cycle after the entry reaches the FIFO head and the output stage frees.
- Throughput: one instruction per cycle in steady state with out_ready held 1.
- Outputs are stable while out_valid & !out_ready.
- in_ready and occupancy are driven from registered state only; there is no combinational path from out_ready to in_ready.

## Configuration
- DECODE_BUFFER_CSR_EN defined:
  - read_enable_csr=1 for SYSTEM with funct3 in {CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI}.
  - write_enable_csr is the same condition, then forced 0 when csr_index[11:10]==2'b11 (read-only CSR).
  - write_enable_csr is also forced 0 for CSRRS/CSRRC with read_index_1==0, and for CSRRSI/CSRRCI with uimm (instruction[19:15])==0.
- DECODE_BUFFER_CSR_EN undefined: read_enable_csr and write_enable_csr are constant 0. SYSTEM still decodes as I.

## Structure
- Opcode constants, instruction-type encodings (including NONE) and CSR funct3 codes live in the shared defines; nothing is local.
- One sub-module: decode_fields, purely combinational. Input: 32-bit instruction. Output: every decoded field, the enables and illegal.
- decode_fields is instantiated once, on the mux of FIFO head and bypass input. Its result is registered in decode_buffer.

## Test plan
- Single ADD x3,x1,x2 (0x002081B3) into an empty buffer with out_ready=1 → out_valid in the next cycle, type R, all three register enables 1, occupancy 0.
- Hold out_ready=0 and push DEPTH+1 instructions:
  - Output stage holds the first; occupancy reaches DEPTH with in_ready=0.
  - Releasing out_ready drains all five in order at one per cycle.
- ADDI x0,x0,0 (0x00000013) → type I, write_enable=0. Opcode 0x7F → illegal=1, type NONE, all enables 0.
- With the macro defined:
  - CSRRS x5,mcycle,x0 → read_enable_csr=1, write_enable_csr=0.
  - CSRRW x0,0xC00,x1 → write_enable_csr=0.
  - CSRRW x0,0x300,x1 → write_enable_csr=1.
- With the macro undefined, all three cases above give CSR enables 0.
- Occupancy 3 with out_valid=1, assert flush for one cycle together with in_valid=1 → next cycle occupancy=0, out_valid=0, in_ready=1, and the flush-cycle instruction never appears at the output.
- Drop reset for one cycle during streaming → occupancy, out_valid and all outputs read 0 immediately, without waiting for a clock edge; streaming restarts cleanly after reset is released.
